dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 182 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Byte-addressed RV32I data memory with 1-cycle load response,
//            lane-masked stores and a sticky access error flag.
//            Optional zero sweep after reset: DMEM_CLEAR_ON_RESET_EN.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] address_DMEM,
    input  logic [31:0]       write_data_DMEM,
    input  logic [2:0]        funct3,
    output logic [31:0]       data_DMEM,
    output logic              rvalid,
    output logic              ready,
    output logic              access_err
);

    localparam int c_idx_w = ADDR_W - 2;
    localparam int c_depth = 2 ** c_idx_w;

    logic [31:0]        r_mem [c_depth];
    logic [31:0]        r_data;
    logic               r_rvalid;
    logic               r_err;

    logic               w_go;
    logic               w_clr_we;
    logic [c_idx_w-1:0] w_clr_idx;
    logic [c_idx_w-1:0] w_idx;
    logic [1:0]         w_off;
    logic               w_rd;
    logic               w_wr;
    logic               w_both;
    logic               w_st_ok;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic               w_ld_ok;
    logic [31:0]        w_ld_val;
    logic [31:0]        w_word;
    logic [15:0]        w_lane;

`ifdef DMEM_CLEAR_ON_RESET_EN
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_idx_w-1:0] r_clr_idx;
    logic               r_ready;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state   <= ST_INIT;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == c_idx_w'(c_depth - 1)) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                ST_IDLE: r_ready <= 1'b1;
                default: begin
                    r_state <= ST_INIT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign w_go      = r_ready;
    assign w_clr_we  = (r_state == ST_INIT);
    assign w_clr_idx = r_clr_idx;
`else
    // No sweep: always ready, but nothing may land in memory while reset is held.
    assign ready     = 1'b1;
    assign w_go      = RSTn;
    assign w_clr_we  = 1'b0;
    assign w_clr_idx = '0;
`endif

    assign w_idx  = address_DMEM[ADDR_W-1:2];
    assign w_off  = address_DMEM[1:0];
    assign w_rd   = w_go &  MemRead & ~MemWrite;
    assign w_wr   = w_go & ~MemRead &  MemWrite;
    assign w_both = w_go &  MemRead &  MemWrite;

    always_comb begin
        w_st_ok = 1'b0;
        w_be    = 4'b0000;
        w_wdata = write_data_DMEM;
        case (funct3)
            3'b000: begin
                w_st_ok = 1'b1;
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{write_data_DMEM[7:0]}};
            end
            3'b001: begin
                w_st_ok = ~w_off[0];
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_data_DMEM[15:0]}};
            end
            3'b010: begin
                w_st_ok = (w_off == 2'b00);
                w_be    = 4'b1111;
            end
            default: ;
        endcase
    end

    // Right-align the addressed byte/half before extension.
    assign w_word = r_mem[w_idx];
    assign w_lane = 16'(w_word >> {w_off, 3'b000});

    always_comb begin
        w_ld_ok  = 1'b0;
        w_ld_val = '0;
        case (funct3)
            3'b000: begin
                w_ld_ok  = 1'b1;
                w_ld_val = {{24{w_lane[7]}}, w_lane[7:0]};
            end
            3'b001: begin
                w_ld_ok  = ~w_off[0];
                w_ld_val = {{16{w_lane[15]}}, w_lane};
            end
            3'b010: begin
                w_ld_ok  = (w_off == 2'b00);
                w_ld_val = w_word;
            end
            3'b100: begin
                w_ld_ok  = 1'b1;
                w_ld_val = {24'h000000, w_lane[7:0]};
            end
            3'b101: begin
                w_ld_ok  = ~w_off[0];
                w_ld_val = {16'h0000, w_lane};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr && w_st_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rvalid <= 1'b0;
            r_data   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) r_data <= w_ld_ok ? w_ld_val : 32'h0;
            if (w_both || (w_rd && !w_ld_ok) || (w_wr && !w_st_ok)) r_err <= 1'b1;
        end
    end

    assign data_DMEM  = r_data;
    assign rvalid     = r_rvalid;
    assign access_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed scoreboard bench for dmem_responder (ADDR_W = 10).
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int ADDR_W = 10;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [9:0]  address_DMEM = '0;
    logic [31:0] write_data_DMEM = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] data_DMEM;
    logic        rvalid;
    logic        ready;
    logic        access_err;

    dmem_responder #(.ADDR_W(ADDR_W)) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .address_DMEM    (address_DMEM),
        .write_data_DMEM (write_data_DMEM),
        .funct3          (funct3),
        .data_DMEM       (data_DMEM),
        .rvalid          (rvalid),
        .ready           (ready),
        .access_err      (access_err)
    );

    always #5 CLK = ~CLK;

    int          nchk = 0;
    int          npass = 0;
    int          nfail = 0;
    logic [31:0] mem_m [256];
    logic        err_m = 1'b0;
    logic [31:0] last_m = '0;
    logic [31:0] q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] ld_model(input logic [31:0] w, input logic [1:0] o,
                                             input logic [2:0] f);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*o +: 8];
        h = o[1] ? w[31:16] : w[15:0];
        case (f)
            3'b000:  return {1'b1, {24{b[7]}}, b};
            3'b100:  return {1'b1, 24'h0, b};
            3'b001:  return o[0] ? 33'h0 : {1'b1, {16{h[15]}}, h};
            3'b101:  return o[0] ? 33'h0 : {1'b1, 16'h0, h};
            3'b010:  return (o == 2'b00) ? {1'b1, w} : 33'h0;
            default: return 33'h0;
        endcase
    endfunction

    task automatic step(input string tag, input logic rd, input logic wr,
                        input logic [9:0] a, input logic [31:0] d, input logic [2:0] f);
        logic [32:0] r;
        logic [31:0] w;
        logic [31:0] e;
        @(negedge CLK);
        MemRead = rd; MemWrite = wr; address_DMEM = a; write_data_DMEM = d; funct3 = f;
        w = mem_m[a[9:2]];
        if (rd && !wr) begin
            r = ld_model(w, a[1:0], f);
            if (!r[32]) err_m = 1'b1;
            q.push_back(r[31:0]);
        end else if (wr && !rd) begin
            case (f)
                3'b000: w[8*a[1:0] +: 8] = d[7:0];
                3'b001: if (a[0]) err_m = 1'b1; else w[16*a[1] +: 16] = d[15:0];
                3'b010: if (a[1:0] != 2'b00) err_m = 1'b1; else w = d;
                default: err_m = 1'b1;
            endcase
            mem_m[a[9:2]] = w;
        end else if (rd && wr) begin
            err_m = 1'b1;
        end
        @(posedge CLK);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
            check({tag, ".data"}, data_DMEM, e);
            last_m = e;
        end else begin
            check({tag, ".rvalid"}, 32'(rvalid), 32'd0);
            check({tag, ".hold"}, data_DMEM, last_m);
        end
        check({tag, ".err"}, 32'(access_err), 32'(err_m));
    endtask

    task automatic wait_sweep(input string tag, input int limit);
        int n = 0;
        while (ready !== 1'b1 && n < limit) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check(tag, 32'(n), 32'd256);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        MemRead = 1'b0; MemWrite = 1'b0;
        RSTn = 1'b0;
        #1;
        check({tag, ".rst_rvalid"}, 32'(rvalid), 32'd0);
        check({tag, ".rst_data"}, data_DMEM, 32'h0);
        check({tag, ".rst_err"}, 32'(access_err), 32'd0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        err_m = 1'b0;
        last_m = '0;
        q.delete();
`ifdef DMEM_CLEAR_ON_RESET_EN
        foreach (mem_m[i]) mem_m[i] = '0;
        wait_sweep({tag, ".sweep_len"}, 400);
`else
        check({tag, ".ready"}, 32'(ready), 32'd1);
`endif
    endtask

    initial begin
        foreach (mem_m[i]) mem_m[i] = '0;
        #2;
        check("por.rvalid", 32'(rvalid), 32'd0);
        check("por.data", data_DMEM, 32'h0);
        check("por.err", 32'(access_err), 32'd0);
`ifdef DMEM_CLEAR_ON_RESET_EN
        // Abort the first sweep at cycle 100; the next must run a full 256 cycles.
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        repeat (100) @(posedge CLK);
        #1;
        check("sweep.mid_ready", 32'(ready), 32'd0);
        RSTn = 1'b0;
        #1;
        check("sweep.abort_ready", 32'(ready), 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        wait_sweep("sweep.restart_len", 400);
        step("clr.lw3fc", 1'b1, 1'b0, 10'h3FC, 32'h0, 3'b010);
        step("clr.lw100", 1'b1, 1'b0, 10'h100, 32'h0, 3'b010);
`else
        do_reset("init");
`endif
        foreach (q[i]) q[i] = '0;
        for (int i = 0; i < 9; i++) step("zero", 1'b0, 1'b1, 10'(i * 4), 32'h0, 3'b010);

        step("sw.beef", 1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 3'b010);
        step("lw.beef", 1'b1, 1'b0, 10'h010, 32'h0, 3'b010);

        step("sw.clr10", 1'b0, 1'b1, 10'h010, 32'h0, 3'b010);
        step("sb.80", 1'b0, 1'b1, 10'h013, 32'h12345680, 3'b000);
        step("lb.13", 1'b1, 1'b0, 10'h013, 32'h0, 3'b000);
        step("lbu.13", 1'b1, 1'b0, 10'h013, 32'h0, 3'b100);
        step("lw.10", 1'b1, 1'b0, 10'h010, 32'h0, 3'b010);

        step("sh.0e", 1'b0, 1'b1, 10'h00E, 32'hFFFFA5C3, 3'b001);
        step("lh.0e", 1'b1, 1'b0, 10'h00E, 32'h0, 3'b001);
        step("lhu.0e", 1'b1, 1'b0, 10'h00E, 32'h0, 3'b101);
        step("lw.0c", 1'b1, 1'b0, 10'h00C, 32'h0, 3'b010);
        step("lb.0d", 1'b1, 1'b0, 10'h00D, 32'h0, 3'b000);

        step("sw.0", 1'b0, 1'b1, 10'h000, 32'h11111111, 3'b010);
        step("sw.4", 1'b0, 1'b1, 10'h004, 32'h22222222, 3'b010);
        step("sw.8", 1'b0, 1'b1, 10'h008, 32'h33333333, 3'b010);
        step("b2b.0", 1'b1, 1'b0, 10'h000, 32'h0, 3'b010);
        step("b2b.4", 1'b1, 1'b0, 10'h004, 32'h0, 3'b010);
        step("b2b.8", 1'b1, 1'b0, 10'h008, 32'h0, 3'b010);
        step("idle", 1'b0, 1'b0, 10'h000, 32'h0, 3'b000);

        step("both.20", 1'b1, 1'b1, 10'h020, 32'hFFFFFFFF, 3'b010);
        step("idle", 1'b0, 1'b0, 10'h000, 32'h0, 3'b000);
        step("lw.20", 1'b1, 1'b0, 10'h020, 32'h0, 3'b010);

        // A load in flight when reset drops must be discarded.
        @(negedge CLK);
        MemRead = 1'b1; MemWrite = 1'b0; address_DMEM = 10'h004; funct3 = 3'b010;
        @(posedge CLK);
        #1;
        check("inflight.rvalid", 32'(rvalid), 32'd1);
        check("inflight.data", data_DMEM, mem_m[1]);
        do_reset("rst2");

        step("keep.lw10", 1'b1, 1'b0, 10'h010, 32'h0, 3'b010);
        step("lh.11", 1'b1, 1'b0, 10'h011, 32'h0, 3'b001);
        step("lw.10b", 1'b1, 1'b0, 10'h010, 32'h0, 3'b010);
        step("lhu.13", 1'b1, 1'b0, 10'h013, 32'h0, 3'b101);
        step("lf3.110", 1'b1, 1'b0, 10'h010, 32'h0, 3'b110);

        do_reset("rst3");
        step("sw.mis22", 1'b0, 1'b1, 10'h022, 32'h12345678, 3'b010);
        step("lw.20b", 1'b1, 1'b0, 10'h020, 32'h0, 3'b010);
        do_reset("rst4");
        step("sf3.011", 1'b0, 1'b1, 10'h020, 32'hA5A5A5A5, 3'b011);
        step("lw.20c", 1'b1, 1'b0, 10'h020, 32'h0, 3'b010);
        step("sh.mis21", 1'b0, 1'b1, 10'h021, 32'h0000BEEF, 3'b001);
        step("lw.20d", 1'b1, 1'b0, 10'h020, 32'h0, 3'b010);
        step("idle", 1'b0, 1'b0, 10'h000, 32'h0, 3'b000);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
`default_nettype wire
